// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg
// Shared types and constants for the mem_burst_ctrl burst sequencer that
// masters the 64 KiB word memory.
//   burst_state_e      : sequencer states
//   MEM_BYTES          : size of the memory in bytes
//   WORD_BYTES         : bytes per memory word
//   ADDR_MSB           : highest byte-address bit that reaches the memory
//   OFF_W / WADDR_W    : byte-offset width and word-address width
//   word_to_byte_addr  : expands a word address onto the 32-bit byte bus
package mem_burst_pkg;

  localparam int unsigned MEM_BYTES  = 65536;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_MSB   = 15;
  localparam int unsigned OFF_W      = $clog2(WORD_BYTES);
  localparam int unsigned WADDR_W    = $clog2(MEM_BYTES / WORD_BYTES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_OUT   = 3'd2,
    WR_FETCH = 3'd3,
    WR_ISSUE = 3'd4
  } burst_state_e;

  // Upper bits and byte-offset bits are always driven zero.
  function automatic logic [31:0] word_to_byte_addr(input logic [WADDR_W-1:0] waddr);
    return {{(32 - WADDR_W - OFF_W){1'b0}}, waddr, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_burst_addr_gen.sv
// mem_burst_addr_gen
// Word-address and remaining-count holder for a burst. Load captures the
// base word address and the length-minus-one; each advance steps the word
// address by one (wrapping inside the 64 KiB space) and decrements the count.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   load_i         : capture addr_i / len_i (has priority over advance_i)
//   advance_i      : step to the next word
//   addr_i         : base word address (byte address bits [15:2])
//   len_i          : word count minus one
//   addr_o         : current byte address, bits [31:16] and [1:0] zero
//   last_o         : current word is the last of the burst
module mem_burst_addr_gen
  import mem_burst_pkg::*;
#(
  parameter int unsigned MAX_LEN_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 advance_i,
  input  logic [WADDR_W-1:0]   addr_i,
  input  logic [MAX_LEN_W-1:0] len_i,
  output logic [31:0]          addr_o,
  output logic                 last_o
);

  logic [WADDR_W-1:0]   waddr_q, waddr_d;
  logic [MAX_LEN_W-1:0] cnt_q, cnt_d;

  // Next word address / remaining count.
  always_comb begin
    waddr_d = waddr_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      waddr_d = addr_i;
      cnt_d   = len_i;
    end else if (advance_i) begin
      // Natural overflow of the word address gives the 0xFFFC -> 0x0000 wrap.
      waddr_d = waddr_q + WADDR_W'(1);
      cnt_d   = cnt_q - MAX_LEN_W'(1);
    end else begin
      waddr_d = waddr_q;
      cnt_d   = cnt_q;
    end
  end

  // Address and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      waddr_q <= {WADDR_W{1'b0}};
      cnt_q   <= {MAX_LEN_W{1'b0}};
    end else begin
      waddr_q <= waddr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign addr_o = word_to_byte_addr(waddr_q);
  assign last_o = (cnt_q == {MAX_LEN_W{1'b0}});

endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
// Burst sequencer in front of the 64 KiB memory. Accepts a burst command and
// performs one single-word access at a time, streaming read words out on the
// rd_* handshake or pulling write words in on the wr_* handshake.
// Optional feature macro: MEM_BURST_CTRL_ALIGN_CHECK_EN
//   defined   : a command with a non-word-aligned address is consumed, no
//               access is issued and err_o pulses for one cycle.
//   undefined : address bits [1:0] are ignored and err_o stays 0.
// Ports:
//   clk_i, rst_ni                       : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o             : command handshake (ready = idle)
//   cmd_write_i, cmd_addr_i, cmd_len_i  : direction, byte address, words-1
//   wr_valid_i/wr_ready_o, wr_data_i    : write-data stream in
//   rd_valid_o/rd_ready_i, rd_data_o    : read-data stream out
//   done_o                              : pulse after the last word completes
//   err_o                               : pulse on a rejected command
//   mem_read_en_o, mem_write_en_o       : memory access strobes
//   mem_addr_o, mem_wdata_o             : memory address and write data
//   mem_rdata_i, mem_ready_i            : memory read data and completion
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int unsigned MAX_LEN_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_write_i,
  input  logic [31:0]          cmd_addr_i,
  input  logic [MAX_LEN_W-1:0] cmd_len_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [31:0]          wr_data_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [31:0]          rd_data_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 mem_read_en_o,
  output logic                 mem_write_en_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i,
  input  logic                 mem_ready_i
);

  burst_state_e       state_q, state_d;
  logic               load_s, adv_s, last_s;
  logic [WADDR_W-1:0] load_waddr_s;
  logic               rd_en_q, wr_en_q, rd_valid_q;
  logic               done_q, done_d, err_q, err_d;
  logic [31:0]        rd_data_q, rd_data_d, wdata_q, wdata_d;
  logic               unused_addr_bits_s;

  // Only bits [15:2] of the command address select a word.
  assign load_waddr_s       = cmd_addr_i[ADDR_MSB:OFF_W];
  assign unused_addr_bits_s = ^{cmd_addr_i[31:ADDR_MSB+1], cmd_addr_i[OFF_W-1:0]};

  mem_burst_addr_gen #(
    .MAX_LEN_W (MAX_LEN_W)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (load_s),
    .advance_i (adv_s),
    .addr_i    (load_waddr_s),
    .len_i     (cmd_len_i),
    .addr_o    (mem_addr_o),
    .last_o    (last_s)
  );

  // Next-state and datapath-capture decode.
  always_comb begin
    state_d   = state_q;
    load_s    = 1'b0;
    adv_s     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_data_d = rd_data_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
`ifdef MEM_BURST_CTRL_ALIGN_CHECK_EN
          if (cmd_addr_i[OFF_W-1:0] != {OFF_W{1'b0}}) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            load_s  = 1'b1;
            state_d = cmd_write_i ? WR_FETCH : RD_ISSUE;
          end
`else
          load_s  = 1'b1;
          state_d = cmd_write_i ? WR_FETCH : RD_ISSUE;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        if (mem_ready_i) begin
          rd_data_d = mem_rdata_i;
          state_d   = RD_OUT;
        end else begin
          state_d = RD_ISSUE;
        end
      end
      RD_OUT: begin
        if (rd_ready_i) begin
          if (last_s) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            adv_s   = 1'b1;
            state_d = RD_ISSUE;
          end
        end else begin
          state_d = RD_OUT;
        end
      end
      WR_FETCH: begin
        if (wr_valid_i) begin
          wdata_d = wr_data_i;
          state_d = WR_ISSUE;
        end else begin
          state_d = WR_FETCH;
        end
      end
      WR_ISSUE: begin
        if (mem_ready_i) begin
          if (last_s) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            adv_s   = 1'b1;
            state_d = WR_FETCH;
          end
        end else begin
          state_d = WR_ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; strobes/valid are the registered decode of
  // the next state so they line up with the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= (state_d == RD_ISSUE);
      wr_en_q    <= (state_d == WR_ISSUE);
      rd_valid_q <= (state_d == RD_OUT);
      done_q     <= done_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      wdata_q    <= wdata_d;
    end
  end

  assign cmd_ready_o    = (state_q == IDLE);
  assign wr_ready_o     = (state_q == WR_FETCH);
  assign mem_read_en_o  = rd_en_q;
  assign mem_write_en_o = wr_en_q;
  assign rd_valid_o     = rd_valid_q;
  assign rd_data_o      = rd_data_q;
  assign mem_wdata_o    = wdata_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl
// Directed bench for mem_burst_ctrl with a behavioural 64 KiB memory.
// Honours MEM_BURST_CTRL_ALIGN_CHECK_EN for the misaligned-command case.
module tb_mem_burst_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [7:0]  cmd_len_i;
  logic        wr_valid_i, wr_ready_o;
  logic [31:0] wr_data_i;
  logic        rd_valid_o, rd_ready_i;
  logic [31:0] rd_data_o;
  logic        done_o, err_o, mem_read_en_o, mem_write_en_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_ready_i;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [31:0] mem [0:16383];
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];
  logic [31:0] rd_got[$];
  logic [31:0] wr_src[$];

  mem_burst_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .done_o(done_o), .err_o(err_o),
    .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  assign mem_rdata_i = mem[mem_addr_o[15:2]];

  // Memory model and access / pulse logging on the active edge.
  always @(posedge clk_i) begin
    if (mem_read_en_o && mem_ready_i) rd_log.push_back(mem_addr_o);
    if (mem_write_en_o && mem_ready_i) begin
      wr_log.push_back(mem_addr_o);
      mem[mem_addr_o[15:2]] = mem_wdata_o;
    end
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
  end

  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [7:0] len);
    int t = 0;
    while (!cmd_ready_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a; cmd_len_i = len;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  // Collects n read words; holds rd_ready_i low for stall_cycles on word stall_word.
  task automatic read_words(input int n, input int stall_word, input int stall_cycles,
                            input logic [31:0] stall_exp);
    int stall_left = stall_cycles;
    int t = 0;
    rd_got.delete();
    while (rd_got.size() < n && t < 400) begin
      @(negedge clk_i);
      t++;
      if (rd_valid_o) begin
        if (rd_got.size() == stall_word && stall_left > 0) begin
          rd_ready_i = 1'b0;
          vectors++;
          if (rd_data_o !== stall_exp || mem_read_en_o !== 1'b0 || rd_log.size() != stall_word + 1) begin
            miscompares++;
            $display("FAIL backpressure_hold: data=%h rd_en=%b strobes=%0d, required data=%h rd_en=0 strobes=%0d",
                     rd_data_o, mem_read_en_o, rd_log.size(), stall_exp, stall_word + 1);
          end
          stall_left--;
        end else begin
          rd_ready_i = 1'b1;
          rd_got.push_back(rd_data_o);
        end
      end
    end
    vectors++;
    if (rd_got.size() != n) begin
      miscompares++;
      $display("FAIL read_timeout: got %0d words, required %0d", rd_got.size(), n);
    end
  endtask

  task automatic write_words(input int n);
    int k = 0;
    int t = 0;
    while (k < n && t < 400) begin
      wr_data_i = wr_src[k];
      wr_valid_i = 1'b1;
      if (wr_ready_o) k++;
      @(negedge clk_i);
      t++;
    end
    wr_valid_i = 1'b0;
    vectors++;
    if (k != n) begin
      miscompares++;
      $display("FAIL write_timeout: sent %0d words, required %0d", k, n);
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    vectors++;
    if ({cmd_ready_o, wr_ready_o, rd_valid_o, done_o, err_o, mem_read_en_o, mem_write_en_o} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, required 1000000",
               {cmd_ready_o, wr_ready_o, rd_valid_o, done_o, err_o, mem_read_en_o, mem_write_en_o});
    end
    vectors++;
    if ({rd_data_o, mem_addr_o, mem_wdata_o} !== 96'h0) begin
      miscompares++;
      $display("FAIL reset_data: rd_data=%h addr=%h wdata=%h, required all 0", rd_data_o, mem_addr_o, mem_wdata_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (cmd_ready_o !== 1'b1 || mem_read_en_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: cmd_ready=%b rd_en=%b, required 1 0", cmd_ready_o, mem_read_en_o);
    end
  endtask

  task automatic test_single_read;
    int d0 = done_cnt;
    rd_log.delete();
    rd_ready_i = 1'b0;
    mem_ready_i = 1'b0;
    send_cmd(1'b0, 32'h0000_0010, 8'd0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({mem_read_en_o, mem_write_en_o, rd_valid_o} !== 3'b100 || mem_addr_o !== 32'h0000_0010) begin
        miscompares++;
        $display("FAIL read_issue_hold: en/we/valid=%b addr=%h, required 100 addr=00000010",
                 {mem_read_en_o, mem_write_en_o, rd_valid_o}, mem_addr_o);
      end
      @(negedge clk_i);
    end
    mem_ready_i = 1'b1;
    read_words(1, -1, 0, 32'h0);
    vectors++;
    if (rd_got[0] !== 32'hDEAD_BEEF || rd_log.size() != 1 || rd_log[0] !== 32'h0000_0010) begin
      miscompares++;
      $display("FAIL single_read: data=%h strobes=%0d addr=%h, required DEADBEEF 1 00000010",
               rd_got[0], rd_log.size(), rd_log[0]);
    end
    @(negedge clk_i);
    vectors++;
    if (done_o !== 1'b1 || cmd_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL done_with_idle: done=%b cmd_ready=%b, required 1 1", done_o, cmd_ready_o);
    end
    repeat (2) @(negedge clk_i);
    vectors++;
    if (done_o !== 1'b0 || done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b pulses=%0d, required 0 1", done_o, done_cnt - d0);
    end
  endtask

  task automatic test_write_readback;
    int d0 = done_cnt;
    wr_log.delete();
    wr_src = '{32'd1, 32'd2, 32'd3, 32'd4};
    send_cmd(1'b1, 32'h0000_0100, 8'd3);
    write_words(4);
    repeat (3) @(negedge clk_i);
    vectors++;
    if (wr_log.size() != 4 || {wr_log[0], wr_log[1], wr_log[2], wr_log[3]} !==
        {32'h100, 32'h104, 32'h108, 32'h10C}) begin
      miscompares++;
      $display("FAIL write_addrs: count=%0d first=%h last=%h, required 4 00000100 0000010c",
               wr_log.size(), wr_log[0], wr_log[3]);
    end
    rd_log.delete();
    rd_ready_i = 1'b0;
    send_cmd(1'b0, 32'h0000_0100, 8'd3);
    vectors++;
    if (mem_read_en_o !== 1'b1 || rd_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL read_latency_n1: rd_en=%b valid=%b, required 1 0", mem_read_en_o, rd_valid_o);
    end
    @(negedge clk_i);
    vectors++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 32'd1) begin
      miscompares++;
      $display("FAIL read_latency_n2: valid=%b data=%h, required 1 00000001", rd_valid_o, rd_data_o);
    end
    read_words(4, -1, 0, 32'h0);
    vectors++;
    if ({rd_got[0], rd_got[1], rd_got[2], rd_got[3]} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      miscompares++;
      $display("FAIL readback_data: got %h %h %h %h, required 1 2 3 4", rd_got[0], rd_got[1], rd_got[2], rd_got[3]);
    end
    repeat (3) @(negedge clk_i);
    vectors++;
    if (rd_log.size() != 4 || rd_log[3] !== 32'h10C || done_cnt - d0 != 2) begin
      miscompares++;
      $display("FAIL readback_strobes: count=%0d last=%h dones=%0d, required 4 0000010c 2",
               rd_log.size(), rd_log[3], done_cnt - d0);
    end
  endtask

  task automatic test_backpressure;
    int d0 = done_cnt;
    rd_log.delete();
    rd_ready_i = 1'b0;
    send_cmd(1'b0, 32'h0000_0100, 8'd3);
    read_words(4, 1, 5, 32'd2);
    repeat (3) @(negedge clk_i);
    vectors++;
    if ({rd_got[0], rd_got[1], rd_got[2], rd_got[3]} !== {32'd1, 32'd2, 32'd3, 32'd4} ||
        rd_log.size() != 4 || done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL backpressure_burst: data %h %h %h %h strobes=%0d dones=%0d, required 1 2 3 4, 4, 1",
               rd_got[0], rd_got[1], rd_got[2], rd_got[3], rd_log.size(), done_cnt - d0);
    end
  endtask

  task automatic test_wrap;
    int e0 = err_cnt;
    wr_log.delete();
    wr_src = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004};
    send_cmd(1'b1, 32'h0000_FFF8, 8'd3);
    write_words(4);
    repeat (3) @(negedge clk_i);
    vectors++;
    if (wr_log.size() != 4 || {wr_log[0], wr_log[1], wr_log[2], wr_log[3]} !==
        {32'hFFF8, 32'hFFFC, 32'h0000, 32'h0004} || err_cnt != e0) begin
      miscompares++;
      $display("FAIL wrap_addrs: %h %h %h %h errs=%0d, required 0000fff8 0000fffc 00000000 00000004 0",
               wr_log[0], wr_log[1], wr_log[2], wr_log[3], err_cnt - e0);
    end
    rd_ready_i = 1'b0;
    send_cmd(1'b0, 32'h0000_FFFC, 8'd1);
    read_words(2, -1, 0, 32'h0);
    vectors++;
    if ({rd_got[0], rd_got[1]} !== {32'hA0A0_0002, 32'hA0A0_0003}) begin
      miscompares++;
      $display("FAIL wrap_readback: got %h %h, required a0a00002 a0a00003", rd_got[0], rd_got[1]);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_misaligned;
    int e0 = err_cnt;
    rd_log.delete();
    rd_ready_i = 1'b0;
`ifdef MEM_BURST_CTRL_ALIGN_CHECK_EN
    send_cmd(1'b0, 32'h0000_0013, 8'd0);
    vectors++;
    if (err_o !== 1'b1 || cmd_ready_o !== 1'b1 || mem_read_en_o !== 1'b0) begin
      miscompares++;
      $display("FAIL misaligned_err: err=%b cmd_ready=%b rd_en=%b, required 1 1 0", err_o, cmd_ready_o, mem_read_en_o);
    end
    repeat (3) @(negedge clk_i);
    vectors++;
    if (err_o !== 1'b0 || err_cnt - e0 != 1 || rd_log.size() != 0) begin
      miscompares++;
      $display("FAIL misaligned_once: err=%b pulses=%0d strobes=%0d, required 0 1 0", err_o, err_cnt - e0, rd_log.size());
    end
`else
    send_cmd(1'b0, 32'h0000_0013, 8'd0);
    read_words(1, -1, 0, 32'h0);
    repeat (2) @(negedge clk_i);
    vectors++;
    if (rd_got[0] !== 32'hDEAD_BEEF || rd_log.size() != 1 || rd_log[0] !== 32'h10 || err_cnt != e0) begin
      miscompares++;
      $display("FAIL misaligned_forced: data=%h addr=%h errs=%0d, required deadbeef 00000010 0",
               rd_got[0], rd_log[0], err_cnt - e0);
    end
`endif
    rd_log.delete();
    rd_ready_i = 1'b0;
    send_cmd(1'b0, 32'hABCD_0104, 8'd0);
    read_words(1, -1, 0, 32'h0);
    repeat (2) @(negedge clk_i);
    vectors++;
    if (rd_got[0] !== 32'd2 || rd_log.size() != 1 || rd_log[0] !== 32'h0000_0104) begin
      miscompares++;
      $display("FAIL high_bits_ignored: data=%h addr=%h, required 00000002 00000104", rd_got[0], rd_log[0]);
    end
  endtask

  task automatic test_reset_mid_burst;
    int d0 = done_cnt;
    int seen = 0;
    int t = 0;
    rd_ready_i = 1'b1;
    send_cmd(1'b0, 32'h0000_0100, 8'd3);
    while (seen < 1 && t < 50) begin
      @(negedge clk_i);
      t++;
      if (rd_valid_o) seen++;
    end
    @(negedge clk_i);
    vectors++;
    if (mem_read_en_o !== 1'b1 || mem_addr_o !== 32'h104) begin
      miscompares++;
      $display("FAIL word2_issue: rd_en=%b addr=%h, required 1 00000104", mem_read_en_o, mem_addr_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    vectors++;
    if ({mem_read_en_o, mem_write_en_o, rd_valid_o, done_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_drop: en/we/valid/done=%b, required 0000",
               {mem_read_en_o, mem_write_en_o, rd_valid_o, done_o});
    end
    rd_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    vectors++;
    if (cmd_ready_o !== 1'b1 || rd_valid_o !== 1'b0 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL reset_mid_burst: cmd_ready=%b valid=%b dones=%0d, required 1 0 0",
               cmd_ready_o, rd_valid_o, done_cnt - d0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEAD_BEEF;
    rst_ni = 1'b0;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 32'h0; cmd_len_i = 8'h0;
    wr_valid_i = 1'b0; wr_data_i = 32'h0; rd_ready_i = 1'b0; mem_ready_i = 1'b1;
    test_reset();
    test_single_read();
    test_write_readback();
    test_backpressure();
    test_wrap();
    test_misaligned();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Burst sequencer directly upstream of `mem_64kib`. Accepts a burst command (base byte address, word count, direction) and issues one single-word access at a time on the memory port. Waits for `ready` on each access. Streams read words out, or pulls write words in, over valid/ready handshakes. It is the only master of the 64 KiB memory in the milestone 3 datapath.

## Interface
- `MAX_LEN_W`, default 8: width of the length field; burst length is `cmd_len_i + 1`, so 1..256 words.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  burst command valid.
- `cmd_ready_o`  out  1  controller idle; command accepted when both valid and ready are high.
- `cmd_write_i`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr_i`  in  32  base byte address.
- `cmd_len_i`  in  MAX_LEN_W  word count minus one.
- `wr_valid_i` / `wr_ready_o`  in/out  1  write-data handshake.
- `wr_data_i`  in  32  write word.
- `rd_valid_o` / `rd_ready_i`  out/in  1  read-data handshake.
- `rd_data_o`  out  32  read word.
- `done_o`  out  1  one-cycle pulse when the last word of a burst completes.
- `err_o`  out  1  one-cycle pulse on a rejected command (see Configuration).
- `mem_read_en_o`, `mem_write_en_o`  out  1  access strobes to memory; mutually exclusive.
- `mem_addr_o`  out  32  memory byte address.
- `mem_wdata_o`  out  32  to memory `d_i`.
- `mem_rdata_i`  in  32  from memory `d_o`.
- `mem_ready_i`  in  1  access complete this cycle.

## Operation
- **IDLE**
  - `cmd_ready_o` = 1.
  - On accept, latch the address, remaining count and direction.
  - Go to RD_ISSUE (read) or WR_FETCH (write).
- **RD_ISSUE**
  - `mem_read_en_o` = 1 and `mem_addr_o` is driven, both held stable until `mem_ready_i`.
  - On `mem_ready_i`, register `mem_rdata_i` into `rd_data_o` and go to RD_OUT.
- **RD_OUT**
  - `rd_valid_o` = 1 and `rd_data_o` is held until `rd_ready_i`.
  - Then either last word: pulse `done_o`, go to IDLE; or advance the address and go to RD_ISSUE.
- **WR_FETCH**
  - `wr_ready_o` = 1.
  - On `wr_valid_i`, latch `wr_data_i` into `mem_wdata_o` and go to WR_ISSUE.
- **WR_ISSUE**
  - `mem_write_en_o` = 1, held stable until `mem_ready_i`.
  - Then either last word: pulse `done_o`, go to IDLE; or advance the address and go to WR_FETCH.
- **Address arithmetic**
  - Advance is +4 on bits [15:2] only; bits [31:16] are driven 0 and bits [1:0] are driven 0.
  - Wrap-around: 0x0000_FFFC + 4 → 0x0000_0000. No error is raised.
- **Address mapping:** `cmd_addr_i[31:16]` is ignored; the address maps into the 64 KiB space.
- **Remaining count:** decremented on each completed access; the last word is the one with count = 0.
- **Command handshake:** commands presented while not IDLE are not accepted and are held by the requester.

## Timing
- **Reset values:**
  - `cmd_ready_o` = 1 (state IDLE).
  - All other outputs = 0: `wr_ready_o`, `rd_valid_o`, `rd_data_o`, `done_o`, `err_o`, both strobes, `mem_addr_o`, `mem_wdata_o`.
- **Registered outputs:** all outputs are registered except `cmd_ready_o` and `wr_ready_o`, which are decoded from state.
- **Read latency:**
  - Command accepted at edge N → `mem_read_en_o` high in cycle N+1.
  - With `mem_ready_i` high in that cycle, `rd_valid_o` is high in cycle N+2.
  - Minimum 2 cycles per read word.
- **Write throughput:** minimum 2 cycles per word (fetch, issue).
- **`mem_ready_i` in a non-issue state:** ignored.
- **`done_o` timing:** asserts in the cycle after the final handshake, coincident with IDLE. A new command may be accepted in that same cycle.
- **Reset mid-burst:**
  - Strobes and valids drop asynchronously.
  - The burst is discarded; no `done_o`.

## Configuration
- **`MEM_BURST_CTRL_ALIGN_CHECK_EN` defined:**
  - A command with `cmd_addr_i[1:0]` ≠ 0 is accepted but issues no access.
  - `err_o` pulses in the next cycle; the state stays IDLE.
- **Not defined:**
  - `cmd_addr_i[1:0]` is silently forced to 0.
  - `err_o` is tied 0.

## Structure
- **Package `mem_burst_pkg`:**
  - State enum `burst_state_e` (IDLE, RD_ISSUE, RD_OUT, WR_FETCH, WR_ISSUE).
  - Constants: `MEM_BYTES` = 65536, `WORD_BYTES` = 4, `ADDR_MSB` = 15.
- **Sub-module `mem_burst_addr_gen`:**
  - Holds the word address and remaining count.
  - Inputs: load, advance.
  - Outputs: address, last flag.
  - The FSM stays in `mem_burst_ctrl`.

## Test plan
- **Single read:** memory preloaded with 0xDEADBEEF at 0x10; read of addr 0x10, len 0 → one read strobe at 0x10, `rd_data_o` = 0xDEADBEEF, then `done_o` pulses.
- **Write then read-back:** write burst at 0x100, len 3, data 1..4 → four strobes at 0x100/104/108/10C; a read burst of the same range returns 1,2,3,4.
- **Backpressure:** read of 4 words with `rd_ready_i` low for 5 cycles on word 2 → `rd_data_o` is held stable and no new `mem_read_en_o` is issued until the handshake.
- **Wrap-around:** write at 0xFFF8, len 3 → addresses 0xFFF8, 0xFFFC, 0x0000, 0x0004; `err_o` stays 0.
- **Misaligned command:** addr 0x13, with the macro → no strobes and `err_o` pulses once. Without the macro → access at 0x10.
- **Reset mid-burst:** `rst_ni` low during word 2 of a 4-word read → all strobes drop immediately; after release, `cmd_ready_o` = 1 and `done_o` never pulsed.
